store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mips_pkg.sv | 19 +
 rtl/sb_fwd_match.sv | 41 ++++
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS core memory path.
//  Revision    : 1.0  initial store buffer support
// ============================================================================
package mips_pkg;

    localparam int SB_DEPTH_DEFAULT  = 4;
    localparam int SB_ADDR_W_DEFAULT = 32;
    localparam int SB_DATA_W_DEFAULT = 32;

    typedef struct packed {
        logic [SB_ADDR_W_DEFAULT-1:0] addr;
        logic [SB_DATA_W_DEFAULT-1:0] data;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fwd_match
//  Description : Youngest-entry word-address match across the live store
//                buffer window, used for store-to-load forwarding.
//  Revision    : 1.0  initial
// ============================================================================
module sb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int WORD_W = 30,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] entryWord,
    input  logic [DEPTH-1:0][DATA_W-1:0] entryData,
    input  logic [PTR_W-1:0]             headPtr,
    input  logic [PTR_W:0]               count,
    input  logic [WORD_W-1:0]            loadWord,
    output logic                         hit,
    output logic [DATA_W-1:0]            hitData
);

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        hit     = 1'b0;
        hitData = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = headPtr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (entryWord[w_idx] == loadWord)) begin
                hit     = 1'b1;
                hitData = entryData[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Circular store FIFO between the core M stage and data memory.
//                Optional store-to-load forwarding under STORE_BUFFER_FWD_EN;
//                without it, loads stall while any store is pending.
//  Revision    : 1.0  initial
// ============================================================================
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              ld_stall,
    output logic              overflow,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int             c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

    logic [c_PTR_W-1:0]            r_head;
    logic [c_PTR_W-1:0]            r_tail;
    logic [c_PTR_W:0]              r_count;
    logic                          r_overflow;
    logic [DEPTH-1:0][ADDR_W-1:0]  r_addrMem;
    logic [DEPTH-1:0][DATA_W-1:0]  r_dataMem;

    logic w_push;
    logic w_pop;

    assign full      = (r_count == c_FULL_CNT);
    assign mem_valid = (r_count != '0);
    assign mem_addr  = r_addrMem[r_head];
    assign mem_wdata = r_dataMem[r_head];
    assign overflow  = r_overflow;

    // full is registered, so a push while full is dropped even if the head pops.
    assign w_push = wr_en && !full;
    assign w_pop  = mem_valid && mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry payload carries no reset; validity comes solely from r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_tail] <= wr_addr;
            r_dataMem[r_tail] <= wr_data;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0][ADDR_W-3:0] w_entryWord;
    logic                         w_hit;
    logic [DATA_W-1:0]            w_hitData;
    logic                         w_unusedByteSel;

    always_comb begin
        w_entryWord = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entryWord[i] = r_addrMem[i][ADDR_W-1:2];
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .WORD_W (ADDR_W-2),
        .DATA_W (DATA_W),
        .PTR_W  (c_PTR_W)
    ) u_fwdMatch (
        .entryWord (w_entryWord),
        .entryData (r_dataMem),
        .headPtr   (r_head),
        .count     (r_count),
        .loadWord  (rd_addr[ADDR_W-1:2]),
        .hit       (w_hit),
        .hitData   (w_hitData)
    );

    assign w_unusedByteSel = ^rd_addr[1:0];
    assign rd_data         = (rd_en && w_hit) ? w_hitData : mem_rdata;
    assign ld_stall        = 1'b0;
`else
    logic w_unusedRdAddr;

    assign w_unusedRdAddr = ^rd_addr;
    assign rd_data        = mem_rdata;
    assign ld_stall       = rd_en && mem_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Queue-based reference model and scoreboard for store_buffer;
//                follows STORE_BUFFER_FWD_EN to select the load model.
//  Revision    : 1.0  initial
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        rdEn;
    logic [31:0] rdAddr;
    logic [31:0] rdData;
    logic        full;
    logic        ldStall;
    logic        overflow;
    logic        memValid;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memReady;
    logic [31:0] memRdata;

    always #5 clk = ~clk;

    assign memRdata = rdAddr ^ 32'hC0DE_0000;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wrEn),
        .wr_addr   (wrAddr),
        .wr_data   (wrData),
        .rd_en     (rdEn),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .full      (full),
        .ld_stall  (ldStall),
        .overflow  (overflow),
        .mem_valid (memValid),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_ready (memReady),
        .mem_rdata (memRdata)
    );

    // Reference state: expQ holds every accepted store not yet seen leaving;
    // mCount is the number of entries the DUT should currently hold.
    logic [63:0] expQ[$];
    int          mCount = 0;
    bit          mOvf   = 1'b0;
    bit          pPush  = 1'b0;
    bit          pPop   = 1'b0;
    bit          pOvf   = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; decides what the coming edge must do.
    task automatic cycle(input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                         input bit rd, input logic [31:0] ra, input bit rdy);
        @(posedge clk);
        #1;
        mCount = mCount + int'(pPush) - int'(pPop);
        if (pOvf) mOvf = 1'b1;
        wrEn     = wr;
        wrAddr   = wa;
        wrData   = wd;
        rdEn     = rd;
        rdAddr   = ra;
        memReady = rdy;
        pPop  = (mCount != 0) && rdy;
        pPush = wr && (mCount != DEPTH);
        pOvf  = wr && (mCount == DEPTH);
        if (pPush) expQ.push_back({wa, wd});
    endtask

    task automatic idleInputs();
        wrEn = 0; wrAddr = '0; wrData = '0;
        rdEn = 0; rdAddr = '0; memReady = 0;
    endtask

    task automatic midReset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mem_valid", memValid, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ld_stall", ldStall, 0);
        idleInputs();
        expQ.delete();
        mCount = 0; mOvf = 0; pPush = 0; pPop = 0; pOvf = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Monitor: compares outputs against the model and retires handshaked stores.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            logic [31:0] eRd;
            check("mem_valid", memValid, 32'(mCount != 0));
            check("full", full, 32'(mCount == DEPTH));
            check("overflow", overflow, 32'(mOvf));
            if (memValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_entry", 32'd1, 32'd0);
                end else begin
                    check("mem_addr", memAddr, expQ[0][63:32]);
                    check("mem_wdata", memWdata, expQ[0][31:0]);
                    if (memReady) void'(expQ.pop_front());
                end
            end
            eRd = rdAddr ^ 32'hC0DE_0000;
`ifdef STORE_BUFFER_FWD_EN
            if (rdEn) begin
                for (int i = 0; i < mCount; i++) begin
                    if (expQ[i][63:34] == rdAddr[31:2]) eRd = expQ[i][31:0];
                end
            end
            check("ld_stall", ldStall, 0);
`else
            check("ld_stall", ldStall, 32'(rdEn && (mCount != 0)));
`endif
            check("rd_data", rdData, eRd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idleInputs();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;

        // Fill under backpressure, overflow, push-while-full with ready, ordered drain.
        cycle(1, 32'h10, 32'h1111_0010, 0, 0, 0);
        cycle(1, 32'h14, 32'h1111_0014, 0, 0, 0);
        cycle(1, 32'h18, 32'h1111_0018, 0, 0, 0);
        cycle(1, 32'h1C, 32'h1111_001C, 0, 0, 0);
        cycle(1, 32'h30, 32'hDEAD_0030, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 32'h40, 32'hDEAD_0040, 0, 0, 1);
        repeat (6) cycle(0, 0, 0, 0, 0, 1);

        // Steady count of two with simultaneous push/pop across pointer wrap.
        cycle(1, 32'h50, 32'h2222_0000, 0, 0, 0);
        cycle(1, 32'h54, 32'h2222_0001, 0, 0, 0);
        for (int k = 0; k < 7; k++) cycle(1, 32'h60 + 32'(k*4), 32'h3333_0000 + 32'(k), 0, 0, 1);
        cycle(1, 32'h80, 32'h4444_0000, 0, 0, 0);
        cycle(1, 32'h84, 32'h4444_0001, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0, 1);

        // Forwarding / stall behaviour on a load that hits pending stores.
        cycle(1, 32'h20, 32'h0000_AAAA, 0, 0, 0);
        cycle(1, 32'h20, 32'h0000_BBBB, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h22, 0);
        #2;
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_youngest", rdData, 32'h0000_BBBB);
`else
        check("stall_pending", ldStall, 1);
`endif
        cycle(0, 0, 0, 1, 32'h24, 0);
        #2;
        check("load_nomatch", rdData, 32'h24 ^ 32'hC0DE_0000);
        repeat (4) cycle(0, 0, 0, 1, 32'h22, 1);
        #2;
        check("drained_stall", ldStall, 0);
        check("drained_rd", rdData, 32'h22 ^ 32'hC0DE_0000);

        // Asynchronous reset half full, then mid-drain with a live handshake.
        cycle(1, 32'h90, 32'h5555_0000, 0, 0, 0);
        cycle(1, 32'h94, 32'h5555_0001, 0, 0, 0);
        midReset();
        cycle(1, 32'hA0, 32'h6666_0000, 0, 0, 0);
        cycle(1, 32'hA4, 32'h6666_0001, 1, 32'hA4, 0);
        cycle(0, 0, 0, 1, 32'hA0, 1);
        midReset();
        cycle(0, 0, 0, 0, 0, 1);

        // Randomized traffic over a small address window to provoke matches.
        for (int k = 0; k < 400; k++) begin
            cycle(bit'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                  $urandom,
                  bit'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)));
        end

        repeat (12) cycle(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("final_queue_empty", 32'(expQ.size()), 0);
        check("final_mem_valid", memValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
